// File: rtl/nn_xor_sequencer.sv
// nn_xor_sequencer: stimulus/collection controller for the float XOR network.
// Walks the four truth-table vectors onto nn_A/nn_B, waits for nn_ready
// (after a short mask window), thresholds nn_result at 0.5 and compares the
// resulting 4-bit pattern against EXPECTED.
// Optional build macro NN_SEQ_CAPTURE_EN adds raw_results, the captured
// nn_result word of every vector.
module nn_xor_sequencer #(
   parameter int                              exp_width      = 8,
   parameter int                              mant_width     = 24,
   parameter logic [exp_width+mant_width-1:0] ONE_VAL        = 32'h3F80_0000,
   parameter logic [exp_width+mant_width-1:0] THRESH         = 32'h3F00_0000,
   parameter int                              MASK_CYCLES    = 2,
   parameter int                              TIMEOUT_CYCLES = 127,
   parameter logic [3:0]                      EXPECTED       = 4'b0110
)(
   input  logic                                clk,
   input  logic                                rst_l,
   input  logic                                start,
   input  logic                                nn_ready,
   input  logic [exp_width+mant_width-1:0]     nn_result,
   output logic [exp_width+mant_width-1:0]     nn_A,
   output logic [exp_width+mant_width-1:0]     nn_B,
   output logic                                busy,
   output logic                                done,
   output logic [3:0]                          result_bits,
   output logic                                pass,
   output logic                                timeout_err
`ifdef NN_SEQ_CAPTURE_EN
   ,
   output logic [4*(exp_width+mant_width)-1:0] raw_results
`endif
);

   localparam int W  = exp_width + mant_width;
   localparam int MW = $clog2(MASK_CYCLES + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [MW-1:0] MASK_LIM = MW'(MASK_CYCLES);
   localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CAPT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      idx;
   logic [MW-1:0]   mask_cnt, mask_nxt;
   logic [TW-1:0]   wait_cnt, wait_nxt;
   logic            rdy_ok, tmo_hit, cap_bit, start_ok;

   // Mask counter saturates once the window is over so long waits cannot wrap it.
   assign mask_nxt = (mask_cnt >= MASK_LIM) ? mask_cnt : mask_cnt + MW'(1);
   assign wait_nxt = wait_cnt + TW'(1);
   // Ready only counts once this WAIT cycle completes the mask window.
   assign rdy_ok   = nn_ready && (mask_nxt >= MASK_LIM);
   assign tmo_hit  = !rdy_ok && (wait_nxt == TMO_LIM);
   // Unsigned magnitude compare is a valid >= for non-negative floats; any
   // negative value (including -0) decides 0.
   assign cap_bit  = !nn_result[W-1] && (nn_result[W-2:0] >= THRESH[W-2:0]);
   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

   // State register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE,
         S_DONE:  if (start_ok) state_nxt = S_DRIVE;
         S_DRIVE: state_nxt = S_WAIT;
         S_WAIT:  begin
            if (rdy_ok)       state_nxt = S_CAPT;
            else if (tmo_hit) state_nxt = S_DONE;
         end
         S_CAPT:  state_nxt = (idx == 2'd3) ? S_DONE : S_DRIVE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs follow the state directly
   always_comb begin
      busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CAPT);
      done = (state == S_DONE);
   end

   // Datapath: vector drive, counters, captured bits and verdict
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         nn_A        <= '0;
         nn_B        <= '0;
         idx         <= '0;
         mask_cnt    <= '0;
         wait_cnt    <= '0;
         result_bits <= '0;
         pass        <= 1'b0;
         timeout_err <= 1'b0;
`ifdef NN_SEQ_CAPTURE_EN
         raw_results <= '0;
`endif
      end else begin
         case (state)
            S_IDLE,
            S_DONE: begin
               if (start_ok) begin
                  result_bits <= '0;
                  pass        <= 1'b0;
                  timeout_err <= 1'b0;
                  idx         <= '0;
`ifdef NN_SEQ_CAPTURE_EN
                  raw_results <= '0;
`endif
               end
            end
            S_DRIVE: begin
               nn_A     <= idx[1] ? ONE_VAL : '0;
               nn_B     <= idx[0] ? ONE_VAL : '0;
               mask_cnt <= '0;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               mask_cnt <= mask_nxt;
               wait_cnt <= wait_nxt;
               if (tmo_hit) begin
                  timeout_err <= 1'b1;
                  pass        <= 1'b0;
               end
            end
            S_CAPT: begin
               result_bits[idx] <= cap_bit;
`ifdef NN_SEQ_CAPTURE_EN
               raw_results[idx*W +: W] <= nn_result;
`endif
               // Last vector: judge with this cycle's bit folded in.
               if (idx == 2'd3) pass <= ({cap_bit, result_bits[2:0]} == EXPECTED);
               else             idx  <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_xor_sequencer.sv
// tb_nn_xor_sequencer: scoreboard bench with a behavioural XOR-network model.
// The driver queues the expected outcome of every run; a monitor pops and
// compares whenever done rises.
module tb_nn_xor_sequencer;

   localparam logic [31:0] ONE   = 32'h3F80_0000;
   localparam int          NEVER = 32'h7FFF_FFFF;

   logic        clk, rst_l, start, nn_ready;
   logic [31:0] nn_result, nn_A, nn_B;
   logic        busy, done, pass, timeout_err;
   logic [3:0]  result_bits;
   logic [127:0] raw_v;

`ifdef NN_SEQ_CAPTURE_EN
   logic [127:0] raw_results;
   assign raw_v = raw_results;
`else
   assign raw_v = '0;
`endif

   nn_xor_sequencer dut (
      .clk(clk), .rst_l(rst_l), .start(start), .nn_ready(nn_ready),
      .nn_result(nn_result), .nn_A(nn_A), .nn_B(nn_B), .busy(busy),
      .done(done), .result_bits(result_bits), .pass(pass),
      .timeout_err(timeout_err)
`ifdef NN_SEQ_CAPTURE_EN
      , .raw_results(raw_results)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- network model ----------------
   logic [31:0] nvals [4];
   int          ndly  [4];
   logic [63:0] nprev;
   int          ncnt;
   logic [1:0]  vi;

   assign vi        = {nn_A != 32'h0, nn_B != 32'h0};
   assign nn_result = nvals[vi];
   assign nn_ready  = (ncnt >= ndly[vi]);

   // Ready drops on every input change and returns ndly cycles later.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         nprev <= '0;
         ncnt  <= 0;
      end else begin
         nprev <= {nn_A, nn_B};
         if ({nn_A, nn_B} != nprev) ncnt <= 0;
         else if (ncnt < 1000000)   ncnt <= ncnt + 1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [3:0]   bits;
      logic         pass;
      logic         tmo;
      logic [31:0]  a;
      logic [31:0]  b;
      int           lat;
      logic [127:0] raw;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, failures = 0;
   int   cyc_start = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // A float is >= 0.5 exactly when it is positive with biased exponent >= 126
   // (exponent 255 covers +inf and positive NaN, both deciding 1).
   function automatic logic ge_half(input logic [31:0] v);
      int e;
      e = int'(v[30:23]);
      return !v[31] && (e >= 126);
   endfunction

   function automatic exp_t model(input int lat);
      exp_t e;
      logic [1:0] iv;
      e.bits = '0; e.tmo = 1'b0; e.raw = '0; e.lat = lat;
      e.a = ONE; e.b = ONE;
      for (int i = 0; i < 4; i++) begin
         if (ndly[i] == NEVER) begin
            iv = i[1:0];
            e.tmo = 1'b1;
            e.a = iv[1] ? ONE : 32'h0;
            e.b = iv[0] ? ONE : 32'h0;
            break;
         end
         e.bits[i] = ge_half(nvals[i]);
         e.raw[i*32 +: 32] = nvals[i];
      end
      e.pass = !e.tmo && (e.bits == 4'b0110);
`ifndef NN_SEQ_CAPTURE_EN
      e.raw = '0;
`endif
      return e;
   endfunction

   // Monitor: compare on every rising edge of done.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_l && done && !done_q) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("result_bits", result_bits, e.bits);
            chk("pass", pass, e.pass);
            chk("timeout_err", timeout_err, e.tmo);
            chk("busy_at_done", busy, 0);
            chk("nn_A_hold", nn_A, e.a);
            chk("nn_B_hold", nn_B, e.b);
            chk("raw_results", raw_v, e.raw);
            if (e.lat >= 0) chk("run_latency", 128'(cyc - cyc_start), 128'(e.lat));
         end
      end
      done_q <= done;
   end

   // ---------------- driver ----------------
   task automatic set_net(input logic [31:0] v0, v1, v2, v3, input int d0, d1, d2, d3);
      nvals[0] = v0; nvals[1] = v1; nvals[2] = v2; nvals[3] = v3;
      ndly[0] = d0; ndly[1] = d1; ndly[2] = d2; ndly[3] = d3;
   endtask

   task automatic run(input int lat, input int pulse_at);
      int k;
      sb.push_back(model(lat));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc_start = cyc;
      if (pulse_at > 0) begin
         repeat (pulse_at) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         chk("done_within_bound", 0, 1);
         void'(sb.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_bits"}, result_bits, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_tmo"}, timeout_err, 0);
      chk({tag, "_nn_A"}, nn_A, 0);
      chk({tag, "_nn_B"}, nn_B, 0);
      chk({tag, "_raw"}, raw_v, 0);
   endtask

   initial begin
      int k;
      logic [31:0] pool [6];
      logic [31:0] rv [4];
      int rd [4];
      pool[0] = 32'h3F00_0000; pool[1] = 32'h3EFF_FFFF; pool[2] = 32'h8000_0000;
      pool[3] = 32'h7FC0_0000; pool[4] = 32'hFFC0_0000; pool[5] = 32'h3F80_0000;

      set_net(32'h3D00_0000, 32'h3F70_0000, 32'h3F60_0000, 32'h3C80_0000, 55, 55, 55, 55);
      start = 1'b0;
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      #1 chk_zero("reset");
      repeat (3) @(negedge clk);
      rst_l = 1'b1;

      // Nominal run: pattern 0110, pass.
      run(-1, 0);
      // Exactly 0.5 decides 1 everywhere.
      set_net(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 7, 7, 7, 7);
      run(-1, 0);
      // Negative values and -0 decide 0.
      set_net(32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 3, 3, 3, 3);
      run(-1, 0);
      // Ready held high: minimum per-vector latency; a mid-run start is ignored.
      set_net(32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 0, 0, 0, 0);
      run(4 * (2 + 2), 6);
      // Vector 2 never becomes ready.
      set_net(32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 0, 0, NEVER, 0);
      run(2 * (2 + 2) + 1 + 127, 0);

      // Randomised runs.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin
            rv[i] = ($urandom_range(0, 2) == 0) ? $urandom() : pool[$urandom_range(0, 5)];
            rd[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 60));
         end
         set_net(rv[0], rv[1], rv[2], rv[3], rd[0], rd[1], rd[2], rd[3]);
         run(-1, 0);
      end

      // Reset during WAIT of vector 1 aborts everything asynchronously.
      set_net(32'h3D00_0000, 32'h3F70_0000, 32'h3F60_0000, 32'h3C80_0000, 55, 55, 55, 55);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(nn_A == 32'h0 && nn_B == ONE) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("reach_vector1", {nn_A, nn_B}, {32'h0, ONE});
      repeat (5) @(negedge clk);
      chk("busy_before_reset", busy, 1);
      #3 rst_l = 1'b0;
      #1 chk_zero("midrun_reset");
      @(negedge clk);
      rst_l = 1'b1;
      run(-1, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nn_xor_sequencer.md
Name: nn_xor_sequencer

Overview:
- Drives the XOR network's A/B input ports through the four truth-table vectors (0,0),(0,1),(1,0),(1,1) as IEEE-754 single values.
- Waits for the network's ready, captures its XOR_output and thresholds it to one bit.
- Compares the 4-bit pattern with an expected pattern.
- Sits on the network's input/output side as its stimulus/collection controller.

Parameters:
- exp_width, 8, exponent width of the float format.
- mant_width, 24, mantissa width including sign bit; word width W = exp_width+mant_width.
- ONE_VAL, 32'h3F80_0000, encoding driven for logic 1 (logic 0 = all zeros).
- THRESH, 32'h3F00_0000, decision threshold (0.5).
- MASK_CYCLES, 2, cycles after a vector change during which nn_ready is ignored.
- TIMEOUT_CYCLES, 127, maximum wait for nn_ready per vector.
- EXPECTED, 4'b0110, expected result_bits.

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- start  in  1  begin a 4-vector run (sampled in IDLE/DONE only)
- nn_ready  in  1  network ready
- nn_result  in  W  network XOR_output
- nn_A  out  W  network input A
- nn_B  out  W  network input B
- busy  out  1  run in progress
- done  out  1  run finished; held until the next accepted start
- result_bits  out  4  bit i = thresholded result of vector i (i = {A,B})
- pass  out  1  done with result_bits==EXPECTED and no timeout
- timeout_err  out  1  a vector exceeded TIMEOUT_CYCLES

Behaviour:
- Clock and reset: one clock, clk; reset rst_l is asynchronous, active-low.
- Reset values: all outputs 0; nn_A = nn_B = 0; state IDLE; vector index 0; counters 0.
- Reset mid-run aborts immediately to these values.
- States: IDLE, DRIVE, WAIT_RDY, CAPTURE, DONE.
- IDLE/DONE, start=1:
  - clear result_bits, pass, timeout_err and done; busy<=1; idx<=0; go DRIVE.
  - start while busy is ignored.
- DRIVE:
  - nn_A <= idx[1] ? ONE_VAL : 0; nn_B <= idx[0] ? ONE_VAL : 0.
  - Mask counter loads 0; go WAIT_RDY.
- WAIT_RDY:
  - Mask counter increments. nn_ready is ignored while mask < MASK_CYCLES, which covers the network's registered ready deassertion after an input change.
  - After the mask, nn_ready=1 → CAPTURE.
  - Wait counter counts every WAIT_RDY cycle. When it reaches TIMEOUT_CYCLES: timeout_err<=1, pass<=0, busy<=0, done<=1, go DONE. Remaining bits stay 0.
- CAPTURE (one cycle):
  - bit = (nn_result[W-1]==0) && (nn_result[W-2:0] >= THRESH[W-2:0]), an unsigned compare valid for positive floats. Negative values and -0 give 0.
  - NaN with sign 0 yields 1; this is accepted.
  - result_bits[idx] <= bit. If idx==3 go DONE, else idx<=idx+1 and go DRIVE.
- Entering DONE normally: busy<=0, done<=1, pass <= ({bit, result_bits[2:0]} == EXPECTED) — the same-cycle value is included.
- nn_A/nn_B hold the last driven vector in DONE and IDLE.
- First vector after reset equals the network's reset history, so no ready drop occurs. The mask plus the ready-high wait still gives correct timing, because the network counts from reset.
- Consecutive vectors always differ in at least one input, so every vector change triggers the network's change detect. A new run starts with (0,0) after (1,1), so this holds across runs too.
- Latency per vector: 1 (DRIVE) + max(MASK_CYCLES, network settle) + 1 (CAPTURE) cycles.

Optional Feature:
- Macro NN_SEQ_CAPTURE_EN.
- Defined:
  - Extra output raw_results [4*W-1:0]; slice i stores nn_result at CAPTURE of vector i.
  - Cleared on reset and on accepted start.
- Undefined: the port does not exist and no storage is built.

Test Plan:
- Reset, then start with a model network returning 0x3D000000, 0x3F700000, 0x3F600000, 0x3C800000, ready 55 cycles after each change → result_bits=4'b0110, pass=1, done=1, busy=0, nn_A=nn_B=0x3F800000.
- Model returns 0x3F000000 (exactly 0.5) for all vectors → result_bits=4'b1111, pass=0.
- Model returns 0xBF800000 (-1.0) and 0x80000000 (-0) → those bits are 0.
- Model holds nn_ready=1 constantly → each vector is captured exactly MASK_CYCLES+1 cycles after DRIVE; run completes in 4 × (MASK_CYCLES+2) cycles.
- Model never asserts ready on vector 2 → timeout_err=1 at wait count 127, done=1, pass=0, result_bits[3:2]=0.
- Pulse start mid-run (ignored); assert rst_l=0 during WAIT_RDY → all outputs 0 asynchronously; a new start then completes normally.
- NN_SEQ_CAPTURE_EN defined, first scenario → raw_results = {0x3C800000, 0x3F600000, 0x3F700000, 0x3D000000}.
